// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI voice allocator slice.
//   - MIDI status nibbles and real-time threshold
//   - parser state encoding
//   - parsed command structure (kind, note, velocity)
package midi_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [7:0] RT_THRESHOLD = 8'hF8;

  typedef enum logic [1:0] {
    S_STATUS = 2'd0,
    S_D1     = 2'd1,
    S_D2     = 2'd2
  } parse_state_t;

  typedef enum logic {
    CMD_NOTE_OFF = 1'b0,
    CMD_NOTE_ON  = 1'b1
  } cmd_kind_t;

  typedef struct packed {
    cmd_kind_t  kind;
    logic [6:0] note;
    logic [6:0] velocity;
  } midi_cmd_t;

  // Real-time bytes may appear anywhere in the stream and must be transparent.
  function automatic logic is_realtime(input logic [7:0] b);
    return b >= RT_THRESHOLD;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: turns the received MIDI byte stream into Note On/Off
// commands, honouring running status and skipping real-time bytes.
// Ports:
//   Clk, Rst_n   clock, synchronous active-low reset
//   byte_valid   one-cycle strobe for byte_data
//   byte_data    received MIDI byte
//   cmd_valid    combinational strobe in the cycle the velocity byte arrives
//   cmd          kind (from the status byte), note, raw velocity
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int MIDI_CHANNEL = 0,
  parameter bit OMNI         = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       cmd_valid,
  output midi_cmd_t  cmd
);

  parse_state_t state, state_next;
  logic         run_valid, run_valid_next;
  cmd_kind_t    run_kind, run_kind_next;
  logic [6:0]   note_q, note_next;

  logic is_rt;
  logic chan_ok;
  logic is_note_status;

  assign is_rt          = is_realtime(byte_data);
  assign chan_ok        = OMNI || (byte_data[3:0] == 4'(MIDI_CHANNEL));
  assign is_note_status = chan_ok &&
                          ((byte_data[7:4] == NOTE_ON) || (byte_data[7:4] == NOTE_OFF));

  // State register, also holding running status and the latched note.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= S_STATUS;
      run_valid <= 1'b0;
      run_kind  <= CMD_NOTE_OFF;
      note_q    <= '0;
    end else begin
      state     <= state_next;
      run_valid <= run_valid_next;
      run_kind  <= run_kind_next;
      note_q    <= note_next;
    end
  end

  // Next-state logic; bytes are only consumed on strobe cycles and
  // real-time bytes leave everything untouched.
  always_comb begin
    state_next     = state;
    run_valid_next = run_valid;
    run_kind_next  = run_kind;
    note_next      = note_q;
    if (byte_valid && !is_rt) begin
      if (byte_data[7]) begin
        if (is_note_status) begin
          run_valid_next = 1'b1;
          run_kind_next  = (byte_data[7:4] == NOTE_ON) ? CMD_NOTE_ON : CMD_NOTE_OFF;
          state_next     = S_D1;
        end else begin
          run_valid_next = 1'b0;
          state_next     = S_STATUS;
        end
      end else begin
        case (state)
          S_STATUS: begin
            // A data byte with no status context is only usable via running status.
            if (run_valid) begin
              note_next  = byte_data[6:0];
              state_next = S_D2;
            end
          end
          S_D1: begin
            note_next  = byte_data[6:0];
            state_next = S_D2;
          end
          S_D2: begin
            state_next = S_D1;
          end
          default: state_next = S_STATUS;
        endcase
      end
    end
  end

  // Command output: valid exactly when the velocity byte completes a message.
  always_comb begin
    cmd_valid    = byte_valid && !byte_data[7] && (state == S_D2);
    cmd.kind     = run_kind;
    cmd.note     = note_q;
    cmd.velocity = byte_data[6:0];
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: parses MIDI Note On/Off and allocates held notes to
// NUM_VOICES stepper voices, stealing round-robin when all are busy.
// Optional macro VOICE_VELOCITY_EN adds the voice_vel output.
// Ports:
//   Clk, Rst_n     clock, synchronous active-low reset
//   byte_valid     one-cycle strobe for byte_data
//   byte_data      received MIDI byte
//   all_notes_off  level; silences every voice while high
//   voice_active   bit i high = voice i sounding
//   voice_note     note of voice i in bits [7i+6:7i]
//   voice_vel      (VOICE_VELOCITY_EN only) velocity of voice i
//   voice_update   pulse when voice outputs change (or on retrigger)
//   steal_event    pulse when a sounding voice was reassigned
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int MIDI_CHANNEL = 0,
  parameter bit OMNI         = 1'b0
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  input  logic                    all_notes_off,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_note,
`ifdef VOICE_VELOCITY_EN
  output logic [7*NUM_VOICES-1:0] voice_vel,
`endif
  output logic                    voice_update,
  output logic                    steal_event
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic      cmd_valid;
  midi_cmd_t cmd;

  midi_msg_parser #(
    .MIDI_CHANNEL (MIDI_CHANNEL),
    .OMNI         (OMNI)
  ) u_parser (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd)
  );

  logic [6:0]            notes [NUM_VOICES];
  logic [PTR_W-1:0]      steal_ptr;
  logic                  aon_q;

  logic                  note_on;
  logic                  note_off;
  logic [NUM_VOICES-1:0] match;
  logic                  hit;
  logic                  free_found;
  logic [PTR_W-1:0]      free_idx;
  logic [PTR_W-1:0]      alloc_idx;
  logic [PTR_W-1:0]      steal_ptr_next;

  // A Note On with zero velocity is treated as a Note Off.
  assign note_on  = cmd_valid && (cmd.kind == CMD_NOTE_ON) && (cmd.velocity != 7'd0);
  assign note_off = cmd_valid && !note_on;

  // Find voices holding the note and the lowest free voice.
  always_comb begin
    match      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      match[i] = voice_active[i] && (notes[i] == cmd.note);
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_active[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
  end

  assign hit            = |match;
  assign alloc_idx      = free_found ? free_idx : steal_ptr;
  assign steal_ptr_next = (steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;

  // Voice state: all_notes_off overrides any command completing that cycle;
  // its pulse is edge-based so a held level reports only once.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      voice_active <= '0;
      steal_ptr    <= '0;
      aon_q        <= 1'b0;
      voice_update <= 1'b0;
      steal_event  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        notes[i] <= '0;
      end
    end else begin
      aon_q        <= all_notes_off;
      voice_update <= 1'b0;
      steal_event  <= 1'b0;
      if (all_notes_off) begin
        voice_active <= '0;
        voice_update <= !aon_q;
      end else if (note_on) begin
        voice_update <= 1'b1;
        if (!hit) begin
          voice_active[alloc_idx] <= 1'b1;
          notes[alloc_idx]        <= cmd.note;
          if (!free_found) begin
            steal_event <= 1'b1;
            steal_ptr   <= steal_ptr_next;
          end
        end
      end else if (note_off && hit) begin
        voice_active <= voice_active & ~match;
        voice_update <= 1'b1;
      end
    end
  end

`ifdef VOICE_VELOCITY_EN
  logic [6:0] vels [NUM_VOICES];

  // Velocity follows the note on allocation and is refreshed on retrigger.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        vels[i] <= '0;
      end
    end else if (!all_notes_off && note_on) begin
      if (hit) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (match[i]) begin
            vels[i] <= cmd.velocity;
          end
        end
      end else begin
        vels[alloc_idx] <= cmd.velocity;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_vel
    assign voice_vel[7*g +: 7] = vels[g];
  end
`endif

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
    assign voice_note[7*g +: 7] = notes[g];
  end

endmodule
